// File: rtl/deframer_pkg.sv
// Shared types and defaults for the bit-stream frame deframer.
package deframer_pkg;

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;

  localparam int unsigned SYNC_W_DEF    = 16;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;
  localparam int unsigned MAX_LEN_DEF   = 64;
  localparam int unsigned TIMEOUT_DEF   = 255;

  // Reasons a frame can end in frame_err.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_LENGTH   = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_cause_t;

endpackage

// File: rtl/deframer_shift8.sv
// MSB-first bit-to-byte assembler; byte_c includes the bit being presented this cycle.
module deframer_shift8 (
  input  logic       clk_x8,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_c,
  output logic       byte_done_c
);

  logic [6:0] sreg;
  logic [2:0] cnt;

  always_ff @(posedge clk_x8 or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (bit_valid) begin
      sreg <= {sreg[5:0], bit_in};
      cnt  <= cnt + 3'd1;
    end
  end

  assign byte_c      = {sreg, bit_in};
  assign byte_done_c = bit_valid && (cnt == 3'd7);

endmodule

// File: rtl/frame_deframer.sv
// Sync hunt, length/payload/checksum deframing of a recovered serial bit stream.
module frame_deframer
  import deframer_pkg::*;
#(
  parameter int unsigned       SYNC_W    = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF),
  parameter int unsigned       MAX_LEN   = MAX_LEN_DEF,
  parameter int unsigned       TIMEOUT   = TIMEOUT_DEF
) (
  input  logic       clk_x8,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       sof,
  output logic [7:0] frame_len,
  output logic       in_frame,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [SYNC_W-1:0] sync_sr;
  logic [7:0]        csum;
  logic [7:0]        bcnt;
  logic [TW-1:0]     tcnt;

  logic [SYNC_W-1:0] sync_next_c;
  logic              sync_hit_c;
  logic              timeout_hit_c;
  logic [7:0]        rx_byte_c;
  logic              byte_done_c;

  assign sync_next_c   = {sync_sr[SYNC_W-2:0], bit_in};
  assign sync_hit_c    = (state == HUNT) && bit_valid && (sync_next_c == SYNC_WORD);
  // Fires on the idle cycle that would take the counter to TIMEOUT.
  assign timeout_hit_c = (state != HUNT) && !bit_valid && (tcnt == TW'(TIMEOUT - 1));

  deframer_shift8 u_shift8 (
    .clk_x8      (clk_x8),
    .rst         (rst),
    .clr         (sync_hit_c | timeout_hit_c),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .byte_c      (rx_byte_c),
    .byte_done_c (byte_done_c)
  );

  // Idle-gap counter, saturating at TIMEOUT.
  always_ff @(posedge clk_x8 or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (bit_valid) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk_x8 or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      sync_sr    <= '0;
      csum       <= '0;
      bcnt       <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      sof        <= 1'b0;
      frame_len  <= '0;
      in_frame   <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      sof        <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      if (timeout_hit_c) begin
        frame_err <= 1'b1;
        state     <= HUNT;
        in_frame  <= 1'b0;
        sync_sr   <= '0;
      end else if (bit_valid) begin
        case (state)
          HUNT: begin
            if (sync_hit_c) begin
              state    <= LEN;
              in_frame <= 1'b1;
              csum     <= '0;
              bcnt     <= '0;
              sync_sr  <= '0;
            end else begin
              sync_sr <= sync_next_c;
            end
          end
          LEN: begin
            if (byte_done_c) begin
              frame_len <= rx_byte_c;
              csum      <= rx_byte_c;
              if (rx_byte_c > 8'(MAX_LEN)) begin
                frame_err <= 1'b1;
                state     <= HUNT;
                in_frame  <= 1'b0;
              end else if (rx_byte_c == 8'd0) begin
                state <= CHECK;
              end else begin
                state <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (byte_done_c) begin
              byte_out   <= rx_byte_c;
              byte_valid <= 1'b1;
              sof        <= (bcnt == 8'd0);
              csum       <= csum + rx_byte_c;
              bcnt       <= bcnt + 8'd1;
              if ((bcnt + 8'd1) == frame_len) state <= CHECK;
            end
          end
          CHECK: begin
            if (byte_done_c) begin
              frame_ok  <= (rx_byte_c == csum);
              frame_err <= (rx_byte_c != csum);
              state     <= HUNT;
              in_frame  <= 1'b0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_deframer.sv
// Randomized bench for frame_deframer against a stream-level reference parser.
`timescale 1ns/1ps
module tb_frame_deframer;
  import deframer_pkg::*;

  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned TIMEOUT = 255;
  localparam int          SYNC    = 16'hA55A;
  localparam logic [1:0]  K_BYTE  = 2'd1;
  localparam logic [1:0]  K_OK    = 2'd2;
  localparam logic [1:0]  K_ERR   = 2'd3;

  logic       clk_x8 = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sof;
  logic [7:0] frame_len;
  logic       in_frame;
  logic       frame_ok;
  logic       frame_err;

  frame_deframer #(
    .SYNC_W(16), .SYNC_WORD(16'hA55A), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_x8(clk_x8), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .sof(sof), .frame_len(frame_len),
    .in_frame(in_frame), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk_x8 = ~clk_x8;

  int          n_vec = 0;
  int          n_bad = 0;
  int          both_cnt = 0;
  int          infr_bits = 0;
  longint      last_set = 0;
  logic [7:0]  model_flen = '0;
  bit          stim[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Event word: kind, sof, data, frame_len, latency in cycles after the last bit_valid.
  function automatic logic [31:0] ev(input logic [1:0] kind, input logic s,
                                     input logic [7:0] d, input logic [7:0] fl, input int lat);
    return {kind, s, d, fl, 13'(lat)};
  endfunction

  always @(negedge clk_x8) begin : mon
    int lat;
    if (!rst) begin
      lat = int'(($time - last_set) / 10) - 1;
      if (byte_valid) obs_q.push_back(ev(K_BYTE, sof, byte_out, frame_len, lat));
      if (frame_ok)   obs_q.push_back(ev(K_OK, 1'b0, 8'h00, frame_len, lat));
      if (frame_err)  obs_q.push_back(ev(K_ERR, 1'b0, 8'h00, frame_len, lat));
      if (frame_ok && frame_err) both_cnt++;
    end
  end

  function automatic logic [7:0] rd8(input int p);
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) v = {v[6:0], stim[p+k]};
    return v;
  endfunction

  // Reference: parse the whole bit list as frames; a stream ending mid-frame times out.
  task automatic run_model();
    int i = 0;
    int n = stim.size();
    int win = 0;
    int len;
    int sum;
    logic [7:0] b;
    while (i < n) begin
      win = ((win << 1) | int'(stim[i])) & 'hFFFF;
      i++;
      if (win != SYNC) continue;
      win = 0;
      if (n - i < 8) begin exp_q.push_back(ev(K_ERR, 1'b0, 8'h00, model_flen, TIMEOUT)); return; end
      len = int'(rd8(i));
      i += 8;
      model_flen = 8'(len);
      sum = len;
      if (len > int'(MAX_LEN)) begin
        exp_q.push_back(ev(K_ERR, 1'b0, 8'h00, model_flen, 0));
        continue;
      end
      for (int k = 0; k < len; k++) begin
        if (n - i < 8) begin exp_q.push_back(ev(K_ERR, 1'b0, 8'h00, model_flen, TIMEOUT)); return; end
        b = rd8(i);
        i += 8;
        exp_q.push_back(ev(K_BYTE, k == 0, b, model_flen, 0));
        sum += int'(b);
      end
      if (n - i < 8) begin exp_q.push_back(ev(K_ERR, 1'b0, 8'h00, model_flen, TIMEOUT)); return; end
      b = rd8(i);
      i += 8;
      exp_q.push_back(ev((b == 8'(sum)) ? K_OK : K_ERR, 1'b0, 8'h00, model_flen, 0));
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int nbits);
    for (int k = nbits - 1; k >= 0; k--) stim.push_back(v[k]);
  endtask

  task automatic send_bit(input bit b, input int gap);
    @(negedge clk_x8);
    bit_in = b;
    bit_valid = 1'b1;
    last_set = $time;
    if (in_frame) infr_bits++;
    @(negedge clk_x8);
    bit_valid = 1'b0;
    bit_in = 1'($urandom);
    repeat (gap) @(negedge clk_x8);
  endtask

  function automatic int count_kind(input logic [1:0] kind);
    int c = 0;
    foreach (obs_q[k]) if (obs_q[k][31:30] == kind) c++;
    return c;
  endfunction

  // gap < 0 selects a random idle gap per bit.
  task automatic run_segment(input string name, input int gap);
    exp_q.delete();
    obs_q.delete();
    infr_bits = 0;
    run_model();
    foreach (stim[i]) send_bit(stim[i], (gap < 0) ? int'($urandom_range(0, 12)) : gap);
    repeat (TIMEOUT + 8) @(negedge clk_x8);
    chk($sformatf("%s_events", name), obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      chk($sformatf("%s_ev%0d", name, k), obs_q[k], exp_q[k]);
    chk($sformatf("%s_idle_in_frame", name), 32'(in_frame), 32'd0);
    stim.delete();
  endtask

  task automatic push_frame(input int len, input bit good);
    int sum = len;
    logic [7:0] b;
    push_bits(SYNC, 16);
    push_bits(len, 8);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      sum += int'(b);
      push_bits(b, 8);
    end
    push_bits(good ? 8'(sum) : 8'(sum + 1 + int'($urandom_range(0, 254))), 8);
  endtask

  initial begin
    repeat (3) @(negedge clk_x8);
    chk("reset_outputs", 32'({byte_out, byte_valid, sof, frame_len, in_frame, frame_ok, frame_err}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_x8);

    push_bits(32'hA55A_0212, 32); push_bits(32'h3448, 16);
    run_segment("good", 6);
    chk("good_ok_cnt", count_kind(K_OK), 1);
    chk("good_err_cnt", count_kind(K_ERR), 0);
    chk("good_frame_len", 32'(frame_len), 32'h02);

    push_bits(32'hA55A_0212, 32); push_bits(32'h3449, 16);
    run_segment("badsum", 6);
    chk("badsum_err_cnt", count_kind(K_ERR), 1);
    chk("badsum_byte_cnt", count_kind(K_BYTE), 2);

    push_bits(32'hA55A_0000, 32);
    run_segment("zerolen", 3);
    chk("zerolen_ok_cnt", count_kind(K_OK), 1);
    chk("zerolen_in_frame_bits", infr_bits, 16);

    push_bits(32'hA55A_41, 24);
    run_segment("oversize", 2);

    push_bits(32'hA55A_03AA, 32);
    run_segment("timeout", 4);

    push_bits(32'hA5, 8);
    for (int k = 0; k < 40; k++) stim.push_back(1'($urandom));
    push_frame(int'($urandom_range(1, 6)), 1'b1);
    run_segment("hunt", -1);

    for (int s = 0; s < 10; s++) begin
      for (int k = int'($urandom_range(0, 20)); k > 0; k--) stim.push_back(1'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        push_bits(SYNC, 16);
        push_bits($urandom_range(MAX_LEN + 1, 255), 8);
      end else begin
        push_frame(int'($urandom_range(0, 12)), $urandom_range(0, 9) < 7);
      end
      if ($urandom_range(0, 5) == 0)
        for (int k = int'($urandom_range(1, 20)); k > 0 && stim.size() > 0; k--) void'(stim.pop_back());
      run_segment($sformatf("rand%0d", s), -1);
    end

    obs_q.delete();
    push_bits(32'hA55A_0411, 32);
    push_bits(3'b001, 3);
    foreach (stim[i]) send_bit(stim[i], 3);
    stim.delete();
    chk("rstmid_first_byte", count_kind(K_BYTE), 1);
    @(negedge clk_x8);
    #2 rst = 1'b1;
    #1 chk("rstmid_outputs", 32'({byte_out, byte_valid, sof, frame_len, in_frame, frame_ok, frame_err}), 32'd0);
    chk("rstmid_no_ok", count_kind(K_OK), 0);
    chk("rstmid_no_err", count_kind(K_ERR), 0);
    obs_q.delete();
    model_flen = '0;
    repeat (2) @(negedge clk_x8);
    rst = 1'b0;
    repeat (TIMEOUT + 8) @(negedge clk_x8);
    chk("rstmid_quiet", obs_q.size(), 0);
    push_frame(5, 1'b1);
    run_segment("after_rst", -1);
    chk("after_rst_ok_cnt", count_kind(K_OK), 1);

    chk("ok_err_exclusive", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
